// File: rtl/mem_arbiter_rr_if.sv
// Signal bundle between the L1 clients, the N-channel arbiter and the single pmem port.
// Handshake: a client holds ch_read/ch_write plus its address/data as a level until its ch_resp bit pulses for one cycle; pmem strobes stay high until pmem_resp.
interface mem_arbiter_rr_if #(
    parameter int NUM_CH = 2,
    parameter int LINE_W = 128,
    parameter int ADDR_W = 16
);
    logic [NUM_CH-1:0]        ch_read;
    logic [NUM_CH-1:0]        ch_write;
    logic [NUM_CH*ADDR_W-1:0] ch_address;
    logic [NUM_CH*LINE_W-1:0] ch_wdata;
    logic [LINE_W-1:0]        ch_rdata;
    logic [NUM_CH-1:0]        ch_resp;
    logic                     pmem_resp;
    logic [LINE_W-1:0]        pmem_rdata;
    logic                     pmem_read;
    logic                     pmem_write;
    logic [ADDR_W-1:0]        pmem_address;
    logic [LINE_W-1:0]        pmem_wdata;
    logic                     busy;
    logic [1:0]               dbg_state;

    modport slave (
        input  ch_read, ch_write, ch_address, ch_wdata, pmem_resp, pmem_rdata,
        output ch_rdata, ch_resp, pmem_read, pmem_write, pmem_address, pmem_wdata,
               busy, dbg_state
    );

    modport master (
        output ch_read, ch_write, ch_address, ch_wdata, pmem_resp, pmem_rdata,
        input  ch_rdata, ch_resp, pmem_read, pmem_write, pmem_address, pmem_wdata,
               busy, dbg_state
    );
endinterface

// File: rtl/mem_arbiter_rr.sv
// N-channel pmem arbiter: round-robin or fixed-priority grant, transaction latched at grant
// so clients cannot disturb an in-flight access; one idle GAP cycle after every completion.
module mem_arbiter_rr #(
    parameter int NUM_CH  = 2,
    parameter int LINE_W  = 128,
    parameter int ADDR_W  = 16,
    parameter int RR_MODE = 1
) (
    input  logic             clk,
    input  logic             reset,
    mem_arbiter_rr_if.slave  bus
);
    localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic [PTR_W-1:0]    grant_q, grant_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [LINE_W-1:0]   wdata_q, wdata_d;
    logic                rd_q, rd_d;
    logic                wr_q, wr_d;
    logic [NUM_CH-1:0]   req;
    logic                any_req;
    logic [PTR_W-1:0]    win;
    logic [NUM_CH-1:0]   resp;

    assign req     = bus.ch_read | bus.ch_write;
    assign any_req = |req;

    // Round-robin searches upward from the slot after the last served channel.
    always_comb begin
        int   idx;
        logic hit;
        win = '0;
        hit = 1'b0;
        idx = 0;
        if (RR_MODE != 0) begin
            for (int k = 1; k <= NUM_CH; k++) begin
                idx = (int'(ptr_q) + k) % NUM_CH;
                if (!hit && req[idx]) begin
                    win = PTR_W'(idx);
                    hit = 1'b1;
                end
            end
        end else begin
            for (int i = NUM_CH - 1; i >= 0; i--) begin
                if (req[i]) win = PTR_W'(i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        resp    = '0;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    grant_d = win;
                    addr_d  = bus.ch_address[win*ADDR_W +: ADDR_W];
                    wdata_d = bus.ch_wdata[win*LINE_W +: LINE_W];
                    // A channel raising both read and write is served as a write.
                    wr_d    = bus.ch_write[win];
                    rd_d    = !bus.ch_write[win];
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (bus.pmem_resp && !reset) begin
                    resp[grant_q] = 1'b1;
                    ptr_d   = grant_q;
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    state_d = GAP;
                end
            end
            GAP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= PTR_W'(NUM_CH - 1);
            grant_q <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
        end
    end

    assign bus.pmem_read    = rd_q;
    assign bus.pmem_write   = wr_q;
    assign bus.pmem_address = addr_q;
    assign bus.pmem_wdata   = wdata_q;
    assign bus.ch_resp      = resp;
    assign bus.ch_rdata     = bus.pmem_rdata;
    assign bus.busy         = (state_q == BUSY);
    assign bus.dbg_state    = state_q;
endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Bench for mem_arbiter_rr: a round-robin and a fixed-priority instance, each checked every
// cycle against a transaction-level model, plus directed scenarios with literal expectations.
module tb_mem_arbiter_rr;
    localparam int N  = 4;
    localparam int AW = 16;
    localparam int LW = 128;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [N-1:0]    rd[2], wr[2];
    logic [N*AW-1:0] addr[2];
    logic [N*LW-1:0] wd[2];
    logic            presp[2];
    logic [LW-1:0]   prdata[2];
    logic [LW-1:0]   o_rdata[2];
    logic [N-1:0]    o_resp[2];
    logic            o_pr[2], o_pw[2], o_busy[2];
    logic [AW-1:0]   o_pa[2];
    logic [LW-1:0]   o_pwd[2];
    logic [1:0]      o_st[2];

    mem_arbiter_rr_if #(.NUM_CH(N), .LINE_W(LW), .ADDR_W(AW)) bus0 ();
    mem_arbiter_rr_if #(.NUM_CH(N), .LINE_W(LW), .ADDR_W(AW)) bus1 ();

    mem_arbiter_rr #(.NUM_CH(N), .LINE_W(LW), .ADDR_W(AW), .RR_MODE(1)) dut_rr (
        .clk(clk), .reset(reset), .bus(bus0));
    mem_arbiter_rr #(.NUM_CH(N), .LINE_W(LW), .ADDR_W(AW), .RR_MODE(0)) dut_fp (
        .clk(clk), .reset(reset), .bus(bus1));

    assign bus0.ch_read = rd[0];      assign bus1.ch_read = rd[1];
    assign bus0.ch_write = wr[0];     assign bus1.ch_write = wr[1];
    assign bus0.ch_address = addr[0]; assign bus1.ch_address = addr[1];
    assign bus0.ch_wdata = wd[0];     assign bus1.ch_wdata = wd[1];
    assign bus0.pmem_resp = presp[0]; assign bus1.pmem_resp = presp[1];
    assign bus0.pmem_rdata = prdata[0]; assign bus1.pmem_rdata = prdata[1];
    assign o_rdata[0] = bus0.ch_rdata;  assign o_rdata[1] = bus1.ch_rdata;
    assign o_resp[0] = bus0.ch_resp;    assign o_resp[1] = bus1.ch_resp;
    assign o_pr[0] = bus0.pmem_read;    assign o_pr[1] = bus1.pmem_read;
    assign o_pw[0] = bus0.pmem_write;   assign o_pw[1] = bus1.pmem_write;
    assign o_busy[0] = bus0.busy;       assign o_busy[1] = bus1.busy;
    assign o_pa[0] = bus0.pmem_address; assign o_pa[1] = bus1.pmem_address;
    assign o_pwd[0] = bus0.pmem_wdata;  assign o_pwd[1] = bus1.pmem_wdata;
    assign o_st[0] = bus0.dbg_state;    assign o_st[1] = bus1.dbg_state;

    task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [LW-1:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Model: transaction record per instance; phase 0 idle, 1 busy, 2 gap.
    int            m_ph[2], m_ptr[2], m_ch[2];
    logic          m_wr[2];
    logic [AW-1:0] m_addr[2];
    logic [LW-1:0] m_wd[2];
    logic [N-1:0]  exp_resp;

    function automatic int pick_winner(input int d, input logic [N-1:0] req, input int ptr);
        if (d == 1) begin
            for (int i = 0; i < N; i++) if (req[i]) return i;
        end else begin
            for (int k = 1; k <= N; k++) if (req[(ptr + k) % N]) return (ptr + k) % N;
        end
        return 0;
    endfunction

    initial begin
        for (int d = 0; d < 2; d++) begin
            m_ph[d] = 0; m_ptr[d] = N - 1; m_ch[d] = 0;
            m_wr[d] = 1'b0; m_addr[d] = '0; m_wd[d] = '0;
        end
        @(posedge clk);
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                exp_resp = '0;
                if (m_ph[d] == 1 && presp[d] && !reset) exp_resp[m_ch[d]] = 1'b1;
                chk($sformatf("d%0d state", d), o_st[d], m_ph[d]);
                chk($sformatf("d%0d busy", d), o_busy[d], m_ph[d] == 1);
                chk($sformatf("d%0d pmem_read", d), o_pr[d], m_ph[d] == 1 && !m_wr[d]);
                chk($sformatf("d%0d pmem_write", d), o_pw[d], m_ph[d] == 1 && m_wr[d]);
                chk($sformatf("d%0d ch_resp", d), o_resp[d], exp_resp);
                chk($sformatf("d%0d ch_rdata", d), o_rdata[d], prdata[d]);
                if (m_ph[d] == 1) begin
                    chk($sformatf("d%0d pmem_address", d), o_pa[d], m_addr[d]);
                    chk($sformatf("d%0d pmem_wdata", d), o_pwd[d], m_wd[d]);
                end
                if (reset) begin
                    m_ph[d] = 0; m_ptr[d] = N - 1;
                end else if (m_ph[d] == 1) begin
                    if (presp[d]) begin m_ph[d] = 2; m_ptr[d] = m_ch[d]; end
                end else if (m_ph[d] == 2) begin
                    m_ph[d] = 0;
                end else if ((rd[d] | wr[d]) != '0) begin
                    m_ch[d]   = pick_winner(d, rd[d] | wr[d], m_ptr[d]);
                    m_wr[d]   = wr[d][m_ch[d]];
                    m_addr[d] = addr[d][m_ch[d]*AW +: AW];
                    m_wd[d]   = wd[d][m_ch[d]*LW +: LW];
                    m_ph[d]   = 1;
                end
            end
        end
    end

    // Memory responder: pmem_resp on the lat-th strobe cycle; stray responses when randomising.
    bit            rand_on = 1'b0;
    int            lat[2], cur_lat[2], cnt[2];
    logic [LW-1:0] fix_data;

    initial begin
        fix_data = {16{8'hA5}};
        for (int d = 0; d < 2; d++) begin
            presp[d] = 1'b0; prdata[d] = '0; cnt[d] = 0; cur_lat[d] = 1;
        end
        forever begin
            @(posedge clk);
            #1;
            for (int d = 0; d < 2; d++) begin
                if (!(o_pr[d] || o_pw[d])) begin
                    cnt[d] = 0;
                    presp[d] = rand_on && ($urandom_range(0, 7) == 0);
                end else begin
                    if (cnt[d] == 0) cur_lat[d] = rand_on ? int'($urandom_range(1, 4)) : lat[d];
                    cnt[d]++;
                    presp[d] = (cnt[d] >= cur_lat[d]);
                    if (presp[d]) cnt[d] = 0;
                end
                prdata[d] = rand_on ? rnd128() : fix_data;
            end
        end
    end

    task automatic wait_resp(input int d, output int n, output bit ok);
        ok = 1'b0;
        n  = 0;
        for (int i = 0; i < 64; i++) begin
            if (o_resp[d] != '0) begin ok = 1'b1; n = i; break; end
            @(negedge clk);
        end
    endtask

    logic [LW-1:0] db;
    logic [N-1:0]  seen[2];
    int            n, stamp[5];
    bit            ok;
    int            exp_g[5] = '{0, 1, 2, 3, 0};

    initial begin
        lat[0] = 3; lat[1] = 2;
        for (int d = 0; d < 2; d++) begin
            rd[d] = '0; wr[d] = '0; addr[d] = '0; wd[d] = '0; seen[d] = '0;
        end
        db = 128'hDEAD0000_11112222_33334444_0000BEEF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("reset pmem_address", o_pa[d], '0);
            chk("reset pmem_wdata", o_pwd[d], '0);
            chk("reset strobes", {o_pr[d], o_pw[d]}, 2'b00);
            chk("reset busy", o_busy[d], 1'b0);
            chk("reset ch_resp", o_resp[d], '0);
        end

        // Single read on channel 1, pmem answers on the third strobe cycle.
        @(posedge clk); #1;
        reset = 1'b0; rd[0][1] = 1'b1; addr[0][1*AW +: AW] = 16'h1230;
        @(negedge clk);
        chk("t1 no strobe yet", o_pr[0], 1'b0);
        @(negedge clk);
        chk("t1 pmem_read", o_pr[0], 1'b1);
        chk("t1 pmem_address", o_pa[0], 16'h1230);
        wait_resp(0, n, ok);
        chk("t1 resp seen", ok, 1'b1);
        chk("t1 resp delay", n, 2);
        chk("t1 ch_resp", o_resp[0], 4'b0010);
        chk("t1 ch_rdata", o_rdata[0], {16{8'hA5}});
        @(posedge clk); #1; rd[0][1] = 1'b0;
        @(negedge clk);
        chk("t1 gap state", o_st[0], 2'd2);
        chk("t1 gap strobes", {o_pr[0], o_pw[0]}, 2'b00);
        @(negedge clk);

        // Write capture: live address/data change mid-access must not reach pmem.
        @(posedge clk); #1;
        lat[0] = 4; wr[0][0] = 1'b1; addr[0][0 +: AW] = 16'h4000; wd[0][0 +: LW] = db;
        @(negedge clk); @(negedge clk);
        chk("t2 pmem_write", {o_pw[0], o_pr[0]}, 2'b10);
        @(posedge clk); #1;
        addr[0][0 +: AW] = 16'h5000; wd[0][0 +: LW] = ~db;
        @(negedge clk);
        chk("t2 address held", o_pa[0], 16'h4000);
        chk("t2 wdata held", o_pwd[0], db);
        wait_resp(0, n, ok);
        chk("t2 resp seen", ok, 1'b1);
        chk("t2 ch_resp", o_resp[0], 4'b0001);
        chk("t2 address at resp", o_pa[0], 16'h4000);
        @(posedge clk); #1; wr[0][0] = 1'b0;
        @(negedge clk); @(negedge clk);

        // Read and write both set on channel 1 is a write.
        @(posedge clk); #1;
        lat[0] = 2; rd[0][1] = 1'b1; wr[0][1] = 1'b1;
        @(negedge clk); @(negedge clk);
        chk("t5 write wins", {o_pw[0], o_pr[0]}, 2'b10);
        wait_resp(0, n, ok);
        chk("t5 resp seen", ok, 1'b1);
        chk("t5 ch_resp", o_resp[0], 4'b0010);
        @(posedge clk); #1; rd[0][1] = 1'b0; wr[0][1] = 1'b0;
        @(negedge clk); @(negedge clk);

        // Reset mid-access abandons it; the held request is then served again.
        @(posedge clk); #1;
        lat[0] = 10; rd[0][0] = 1'b1; addr[0][0 +: AW] = 16'h0777;
        @(negedge clk); @(negedge clk);
        chk("t6 busy before reset", o_busy[0], 1'b1);
        @(posedge clk); #1; reset = 1'b1;
        @(posedge clk); #1; reset = 1'b0; lat[0] = 2;
        @(negedge clk);
        chk("t6 state after reset", o_st[0], 2'd0);
        chk("t6 strobe after reset", o_pr[0], 1'b0);
        chk("t6 no resp after reset", o_resp[0], 4'b0000);
        wait_resp(0, n, ok);
        chk("t6 resp seen", ok, 1'b1);
        chk("t6 ch_resp", o_resp[0], 4'b0001);
        @(posedge clk); #1; rd[0][0] = 1'b0;
        @(negedge clk); @(negedge clk);

        // Round robin with all four channels requesting, one-cycle pmem.
        @(posedge clk); #1; reset = 1'b1;
        @(posedge clk); #1; reset = 1'b0; lat[0] = 1; rd[0] = 4'hF;
        @(negedge clk);
        for (int g = 0; g < 5; g++) begin
            wait_resp(0, n, ok);
            chk("t3 resp seen", ok, 1'b1);
            chk($sformatf("t3 grant %0d", g), o_resp[0], 4'b0001 << exp_g[g]);
            stamp[g] = cyc;
            if (g > 0) chk($sformatf("t3 spacing %0d", g), stamp[g] - stamp[g-1], 3);
            @(negedge clk);
        end
        @(posedge clk); #1; rd[0] = '0;
        @(negedge clk); @(negedge clk);

        // Fixed priority: channel 0 always beats channel 2 until it drops out.
        @(posedge clk); #1; rd[1] = 4'b0101;
        @(negedge clk);
        for (int g = 0; g < 4; g++) begin
            wait_resp(1, n, ok);
            chk("t4 resp seen", ok, 1'b1);
            chk($sformatf("t4 grant %0d", g), o_resp[1], 4'b0001);
            @(negedge clk);
        end
        @(posedge clk); #1; rd[1][0] = 1'b0;
        @(negedge clk);
        wait_resp(1, n, ok);
        chk("t4 resp seen after drop", ok, 1'b1);
        chk("t4 ch2 granted", o_resp[1], 4'b0100);
        @(posedge clk); #1; rd[1] = '0;
        @(negedge clk); @(negedge clk);

        // Random clients on both instances, with occasional reset pulses.
        @(posedge clk); #1; rand_on = 1'b1;
        repeat (4000) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) seen[d] = o_resp[d];
            @(posedge clk); #1;
            reset = ($urandom_range(0, 599) == 0);
            for (int d = 0; d < 2; d++) begin
                for (int c = 0; c < N; c++) begin
                    if (seen[d][c]) begin
                        rd[d][c] = 1'b0; wr[d][c] = 1'b0;
                    end else if (!(rd[d][c] || wr[d][c])) begin
                        if ($urandom_range(0, 2) == 0) begin
                            n = $urandom_range(0, 2);
                            rd[d][c] = (n != 1);
                            wr[d][c] = (n != 0);
                            addr[d][c*AW +: AW] = 16'($urandom());
                            wd[d][c*LW +: LW] = rnd128();
                        end
                    end else begin
                        if ($urandom_range(0, 15) == 0) begin
                            addr[d][c*AW +: AW] = 16'($urandom());
                            wd[d][c*LW +: LW] = rnd128();
                        end
                        if ($urandom_range(0, 63) == 0) begin
                            rd[d][c] = 1'b0; wr[d][c] = 1'b0;
                        end
                    end
                end
            end
        end
        @(posedge clk); #1;
        rand_on = 1'b0; reset = 1'b0;
        for (int d = 0; d < 2; d++) begin rd[d] = '0; wr[d] = '0; end
        repeat (30) @(posedge clk);
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
